// File: rtl/gaussian_pkg.sv
// Shared constants for the 3x3 Gaussian blur kernel [1 2 1; 2 4 2; 1 2 1].
package gaussian_pkg;

    // Kernel weights: corner, edge and centre taps.
    localparam int unsigned KERNEL_W_CORNER = 1;
    localparam int unsigned KERNEL_W_EDGE   = 2;
    localparam int unsigned KERNEL_W_CENTRE = 4;

    // The weights sum to 16, so dividing the total by 16 normalises the result.
    localparam int unsigned KERNEL_SHIFT = 4;

    // Guard bits added above the pixel width for the intermediate sums.
    localparam int unsigned SUM_GUARD = 4;

    // Weights are powers of two, so every tap weight becomes a left shift.
    localparam int unsigned CORNER_SHIFT     = $clog2(KERNEL_W_CORNER);
    localparam int unsigned EDGE_SHIFT       = $clog2(KERNEL_W_EDGE);
    localparam int unsigned OUTER_ROW_SHIFT  = 0;
    localparam int unsigned MIDDLE_ROW_SHIFT = $clog2(KERNEL_W_CENTRE / KERNEL_W_EDGE);

endpackage : gaussian_pkg

// File: rtl/gaussian_row_sum.sv
// Weighted sum of one kernel row: (left + 2*centre + right) << ROW_SHIFT.
module gaussian_row_sum
    import gaussian_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ROW_SHIFT = 0
) (
    input  logic [3*WIDTH-1:0]         row_in,
    output logic [WIDTH+SUM_GUARD-1:0] sum_c
);

    localparam int unsigned SUM_W = WIDTH + SUM_GUARD;

    logic [SUM_W-1:0] left_c;
    logic [SUM_W-1:0] centre_c;
    logic [SUM_W-1:0] right_c;

    // Unpack the row, zero-extend each pixel and apply the tap weights by shifting.
    always_comb begin
        left_c   = SUM_W'(row_in[3*WIDTH-1:2*WIDTH]);
        centre_c = SUM_W'(row_in[2*WIDTH-1:WIDTH]);
        right_c  = SUM_W'(row_in[WIDTH-1:0]);
        sum_c    = ((left_c << CORNER_SHIFT) + (centre_c << EDGE_SHIFT)
                    + (right_c << CORNER_SHIFT)) << ROW_SHIFT;
    end

endmodule : gaussian_row_sum

// File: rtl/gaussian.sv
// 3x3 Gaussian blur of one pixel neighbourhood, two-stage pipeline, one sample in flight.
module gaussian
    import gaussian_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [3*WIDTH-1:0] r0_data_in,
    input  logic [3*WIDTH-1:0] r1_data_in,
    input  logic [3*WIDTH-1:0] r2_data_in,
    input  logic               data_valid_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid_out,
    output logic               error_out,
    output logic               busy_out
);

    localparam int unsigned SUM_W = WIDTH + SUM_GUARD;

    logic [SUM_W-1:0] r0_sum_c, r1_sum_c, r2_sum_c;
    logic [SUM_W-1:0] r0_sum_q, r1_sum_q, r2_sum_q;
    logic [SUM_W-1:0] r0_sum_d, r1_sum_d, r2_sum_d;
    logic [SUM_W-1:0] total_c;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             busy_c;
    logic             accept_c;

    gaussian_row_sum #(.WIDTH(WIDTH), .ROW_SHIFT(OUTER_ROW_SHIFT)) u_row0 (
        .row_in (r0_data_in),
        .sum_c  (r0_sum_c)
    );

    gaussian_row_sum #(.WIDTH(WIDTH), .ROW_SHIFT(MIDDLE_ROW_SHIFT)) u_row1 (
        .row_in (r1_data_in),
        .sum_c  (r1_sum_c)
    );

    gaussian_row_sum #(.WIDTH(WIDTH), .ROW_SHIFT(OUTER_ROW_SHIFT)) u_row2 (
        .row_in (r2_data_in),
        .sum_c  (r2_sum_c)
    );

    // Next-state: accept only when idle, flag strobes that arrive while busy.
    always_comb begin
        busy_c     = s1_valid_q | valid_q;
        accept_c   = data_valid_in & ~busy_c;
        s1_valid_d = accept_c;
        r0_sum_d   = r0_sum_q;
        r1_sum_d   = r1_sum_q;
        r2_sum_d   = r2_sum_q;
        total_c    = r0_sum_q + r1_sum_q + r2_sum_q;
        valid_d    = s1_valid_q;
        data_d     = data_q;
        error_d    = data_valid_in & busy_c;
        if (accept_c) begin
            r0_sum_d = r0_sum_c;
            r1_sum_d = r1_sum_c;
            r2_sum_d = r2_sum_c;
        end
        if (s1_valid_q) begin
            data_d = WIDTH'(total_c >> KERNEL_SHIFT);
        end
    end

    // Pipeline registers with synchronous reset that also drops any in-flight sample.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid_q <= 1'b0;
            r0_sum_q   <= '0;
            r1_sum_q   <= '0;
            r2_sum_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            r0_sum_q   <= r0_sum_d;
            r1_sum_q   <= r1_sum_d;
            r2_sum_q   <= r2_sum_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign error_out      = error_q;
    assign busy_out       = busy_c;

endmodule : gaussian

// File: tb/tb_gaussian.sv
// Directed self-checking bench for the gaussian blur block (WIDTH = 8).
module tb_gaussian;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [23:0] r0_data_in;
    logic [23:0] r1_data_in;
    logic [23:0] r2_data_in;
    logic        data_valid_in;
    logic [7:0]  data_out;
    logic        data_valid_out;
    logic        error_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] r0;
        logic [23:0] r1;
        logic [23:0] r2;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[8];

    gaussian #(.WIDTH(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .r0_data_in     (r0_data_in),
        .r1_data_in     (r1_data_in),
        .r2_data_in     (r2_data_in),
        .data_valid_in  (data_valid_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .error_out      (error_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic cycle();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic set_rows(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        r0_data_in = a;
        r1_data_in = b;
        r2_data_in = c;
    endtask

    task automatic scramble_rows();
        set_rows(24'($urandom), 24'($urandom), 24'($urandom));
    endtask

    task automatic check_out(input string tag, input int dv, input int d, input int err, input int busy);
        check({tag, ".valid"}, int'(data_valid_out), dv);
        if (d >= 0) check({tag, ".data"}, int'(data_out), d);
        check({tag, ".error"}, int'(error_out), err);
        check({tag, ".busy"}, int'(busy_out), busy);
    endtask

    initial begin
        // left, centre, right packed as {L, C, R}
        vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 8'd255};
        vecs[1] = '{24'h000000, 24'h001000, 24'h000000, 8'd4};
        vecs[2] = '{24'h100000, 24'h000000, 24'h000000, 8'd1};
        vecs[3] = '{24'h000000, 24'h000F00, 24'h000000, 8'd3};
        vecs[4] = '{24'h102030, 24'h102030, 24'h102030, 8'd32};
        vecs[5] = '{24'h000000, 24'h000000, 24'h000000, 8'd0};
        vecs[6] = '{24'h0000FF, 24'h0000C8, 24'h000000, 8'd40};
        vecs[7] = '{24'h000000, 24'h000000, 24'h006400, 8'd12};

        rst_in        = 1'b1;
        data_valid_in = 1'b1;
        set_rows(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        @(negedge clk_in);
        cycle();
        check_out("reset", 0, 0, 0, 0);
        cycle();
        check_out("reset_hold", 0, 0, 0, 0);
        data_valid_in = 1'b0;
        rst_in        = 1'b0;
        cycle();
        check_out("idle", 0, 0, 0, 0);

        // Table-driven single-sample vectors: latency, busy window and hold.
        for (int i = 0; i < 8; i++) begin
            set_rows(vecs[i].r0, vecs[i].r1, vecs[i].r2);
            data_valid_in = 1'b1;
            cycle();
            data_valid_in = 1'b0;
            scramble_rows();
            check_out($sformatf("vec%0d.t1", i), 0, -1, 0, 1);
            cycle();
            check_out($sformatf("vec%0d.t2", i), 1, int'(vecs[i].exp), 0, 1);
            cycle();
            check_out($sformatf("vec%0d.t3", i), 0, int'(vecs[i].exp), 0, 0);
        end

        // Strobe at T and T+1: only the first sample is processed.
        set_rows(vecs[1].r0, vecs[1].r1, vecs[1].r2);
        data_valid_in = 1'b1;
        cycle();
        set_rows(vecs[0].r0, vecs[0].r1, vecs[0].r2);
        check_out("drop.t1", 0, -1, 0, 1);
        cycle();
        data_valid_in = 1'b0;
        check_out("drop.t2", 1, 4, 1, 1);
        cycle();
        check_out("drop.t3", 0, 4, 0, 0);
        cycle();
        check_out("drop.t4", 0, 4, 0, 0);

        // Strobe at T+2 (still busy) is also dropped and flagged one cycle later.
        set_rows(vecs[4].r0, vecs[4].r1, vecs[4].r2);
        data_valid_in = 1'b1;
        cycle();
        data_valid_in = 1'b0;
        cycle();
        set_rows(vecs[0].r0, vecs[0].r1, vecs[0].r2);
        data_valid_in = 1'b1;
        check_out("late.t2", 1, 32, 0, 1);
        cycle();
        data_valid_in = 1'b0;
        check_out("late.t3", 0, 32, 1, 0);
        cycle();
        check_out("late.t4", 0, 32, 0, 0);

        // Reset at T+1 abandons the sample; a later sample works normally.
        set_rows(vecs[0].r0, vecs[0].r1, vecs[0].r2);
        data_valid_in = 1'b1;
        cycle();
        data_valid_in = 1'b0;
        rst_in        = 1'b1;
        check_out("rst.t1", 0, -1, 0, 1);
        cycle();
        rst_in = 1'b0;
        check_out("rst.t2", 0, 0, 0, 0);
        cycle();
        check_out("rst.t3", 0, 0, 0, 0);
        set_rows(vecs[4].r0, vecs[4].r1, vecs[4].r2);
        data_valid_in = 1'b1;
        cycle();
        data_valid_in = 1'b0;
        cycle();
        check_out("rst.after", 1, 32, 0, 1);
        cycle();

        // Back-to-back at the maximum rate: strobes at T and T+3.
        set_rows(vecs[4].r0, vecs[4].r1, vecs[4].r2);
        data_valid_in = 1'b1;
        cycle();
        data_valid_in = 1'b0;
        check_out("b2b.t1", 0, -1, 0, 1);
        cycle();
        check_out("b2b.t2", 1, 32, 0, 1);
        cycle();
        check_out("b2b.t3", 0, 32, 0, 0);
        set_rows(vecs[0].r0, vecs[0].r1, vecs[0].r2);
        data_valid_in = 1'b1;
        cycle();
        data_valid_in = 1'b0;
        check_out("b2b.t4", 0, 32, 0, 1);
        cycle();
        check_out("b2b.t5", 1, 255, 0, 1);
        cycle();
        check_out("b2b.t6", 0, 255, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gaussian
